// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and 8N1 frame constants.
// Used by both the receiver and the transmitter so the wire format stays in one place.
// No logic here; constants and types only.
package uart_pkg;

    typedef enum logic [2:0] {
        s_IDLE     = 3'd0,
        s_STARTBIT = 3'd1,
        s_DATABITS = 3'd2,
        s_STOPBIT  = 3'd3,
        s_CLEANUP  = 3'd4
    } uart_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous bit.
// Latency: 2 clocks from input change to q.
// Backpressure: none; free-running every clock.
// Ports: clk (rising edge), reset_n (synchronous, active low, loads RESET_VAL),
//        d (asynchronous input), q (synchronised output).
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, idle-high line, centre sampling from the start edge.
// Latency: line fall to busy 3 clocks; stop-bit sample to done/error strobe 1 clock.
// Backpressure: none; o_rxData is held until the next good frame, consumer must take it on o_rxDone.
// Ports: i_clock, i_resetN (sync, active low), i_rxSerial (async line),
//        o_rxData (last good byte), o_rxDone / o_rxError (1-cycle strobes), o_rxBusy (frame in progress).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_SPEED = 1000000,
    parameter int BAUD_RATE   = 9600
) (
    input  logic       i_clock,
    input  logic       i_resetN,
    input  logic       i_rxSerial,
    output logic [7:0] o_rxData,
    output logic       o_rxDone,
    output logic       o_rxError,
    output logic       o_rxBusy
);

    localparam int          CLOCKS_PER_BIT = CLOCK_SPEED / BAUD_RATE;
    localparam logic [15:0] CPB            = 16'(CLOCKS_PER_BIT);
    localparam logic [15:0] HALF           = 16'(CLOCKS_PER_BIT / 2);
    localparam logic [2:0]  LAST_BIT       = 3'(DATA_BITS - 1);

    logic        rx_s;
    logic        rx_prev;
    uart_state_t state,   state_n;
    logic [15:0] count,   count_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shift,   shift_n;
    logic [7:0]  data_q,  data_n;
    logic        done_q,  done_n;
    logic        err_q,   err_n;

    sync_2ff #(.RESET_VAL(IDLE_LEVEL)) u_sync (
        .clk     (i_clock),
        .reset_n (i_resetN),
        .d       (i_rxSerial),
        .q       (rx_s)
    );

    always_ff @(posedge i_clock) begin
        if (!i_resetN) begin
            state   <= s_IDLE;
            count   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rx_prev <= IDLE_LEVEL;
        end else begin
            state   <= state_n;
            count   <= count_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            data_q  <= data_n;
            done_q  <= done_n;
            err_q   <= err_n;
            rx_prev <= rx_s;
        end
    end

    always_comb begin
        state_n   = state;
        count_n   = count;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        data_n    = data_q;
        done_n    = 1'b0;
        err_n     = 1'b0;

        case (state)
            s_IDLE: begin
                count_n   = '0;
                bit_idx_n = '0;
                // Edge only: a line that stays low after a break never retriggers.
                if (rx_prev == IDLE_LEVEL && rx_s != IDLE_LEVEL)
                    state_n = s_STARTBIT;
            end

            s_STARTBIT: begin
                if (count == HALF) begin
                    count_n = '0;
                    // Line back high at mid start bit means it was a glitch.
                    state_n = (rx_s == IDLE_LEVEL) ? s_IDLE : s_DATABITS;
                end else begin
                    count_n = count + 16'd1;
                end
            end

            s_DATABITS: begin
                if (count == CPB) begin
                    count_n          = '0;
                    shift_n[bit_idx] = rx_s;
                    if (bit_idx == LAST_BIT)
                        state_n = s_STOPBIT;
                    else
                        bit_idx_n = bit_idx + 3'd1;
                end else begin
                    count_n = count + 16'd1;
                end
            end

            s_STOPBIT: begin
                if (count == CPB) begin
                    count_n = '0;
                    state_n = s_CLEANUP;
                    // Strobes and data are registered here so they are visible
                    // together for exactly the single CLEANUP cycle.
                    if (rx_s == STOP_LEVEL) begin
                        data_n = shift;
                        done_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end else begin
                    count_n = count + 16'd1;
                end
            end

            s_CLEANUP: begin
                count_n = '0;
                state_n = s_IDLE;
            end

            default: begin
                count_n = '0;
                state_n = s_IDLE;
            end
        endcase
    end

    assign o_rxData  = data_q;
    assign o_rxDone  = done_q;
    assign o_rxError = err_q;
    assign o_rxBusy  = (state != s_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at default parameters (105-clock bit period).
// A line-level sender drives frames; a queue of expected bytes and error counts
// describes what the receiver must report.
module tb_uart_rx;

    localparam int BIT_P  = 105;
    localparam int HALF_P = 52;

    logic       clk = 1'b0;
    logic       resetn;
    logic       rx_line;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_error;
    logic       rx_busy;

    uart_rx dut (
        .i_clock    (clk),
        .i_resetN   (resetn),
        .i_rxSerial (rx_line),
        .o_rxData   (rx_data),
        .o_rxDone   (rx_done),
        .o_rxError  (rx_error),
        .o_rxBusy   (rx_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Observation side
    int         cyc = 0;
    logic [7:0] got_q[$];
    int         n_done = 0;
    int         n_errp = 0;
    int         done_cyc = 0;
    int         both_seen = 0;
    int         busy_run = 0;
    int         last_busy_run = 0;

    // Reference model side
    logic [7:0] exp_q[$];
    int         exp_err = 0;
    logic [7:0] last_good = 8'h00;
    int         start_cyc = 0;
    logic       busy_at2, busy_at3;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done === 1'b1) begin
            got_q.push_back(rx_data);
            n_done   = n_done + 1;
            done_cyc = cyc;
        end
        if (rx_error === 1'b1) n_errp = n_errp + 1;
        if (rx_done === 1'b1 && rx_error === 1'b1) both_seen = both_seen + 1;
        if (rx_busy === 1'b1) busy_run = busy_run + 1;
        else if (busy_run != 0) begin
            last_busy_run = busy_run;
            busy_run      = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one 8N1 frame. abort_at>0 pulses reset that many clocks into the
    // frame and releases the line high, as if the sender gave up.
    task automatic send_frame(input logic [7:0] d, input int period, input logic stop,
                              input int abort_at);
        logic [9:0] bits;
        int t;
        bits = {stop, d, 1'b0};
        t    = 0;
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            rx_line = bits[i];
            for (int k = 0; k < period; k++) begin
                tick(1);
                t++;
                if (t == 2) busy_at2 = rx_busy;
                if (t == 3) busy_at3 = rx_busy;
                if (abort_at != 0 && t == abort_at) begin
                    resetn = 1'b0;
                    tick(1);
                    resetn  = 1'b1;
                    rx_line = 1'b1;
                    return;
                end
            end
        end
        if (stop) begin
            exp_q.push_back(d);
            last_good = d;
        end else begin
            exp_err++;
        end
    endtask

    task automatic check_frames(input string tag);
        logic [7:0] g, e;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_data"}, g, e);
        end
        got_q.delete();
        exp_q.delete();
        check({tag, "_errs"}, n_errp, exp_err);
    endtask

    initial begin
        int done_before, gap;
        logic [7:0] rb;
        int rp;

        // Reset with idle line
        resetn  = 1'b0;
        rx_line = 1'b1;
        tick(4);
        check("rst_data", rx_data, 8'h00);
        check("rst_done", rx_done, 1'b0);
        check("rst_error", rx_error, 1'b0);
        check("rst_busy", rx_busy, 1'b0);
        resetn = 1'b1;
        tick(20);

        // 0xA5 at nominal rate: busy latency, done latency, idle before line idles a bit
        send_frame(8'hA5, BIT_P, 1'b1, 0);
        check("busy_lat_2clk", busy_at2, 1'b0);
        check("busy_lat_3clk", busy_at3, 1'b1);
        check("busy_low_at_stop_end", rx_busy, 1'b0);
        check("done_latency_window",
              ((done_cyc - start_cyc) >= 3 + HALF_P + 9 * BIT_P - 1) &&
              ((done_cyc - start_cyc) <= 3 + HALF_P + 9 * BIT_P + 3), 1'b1);
        check_frames("a5");
        tick(BIT_P);

        // Back-to-back 0x00 then 0xFF
        send_frame(8'h00, BIT_P, 1'b1, 0);
        send_frame(8'hFF, BIT_P, 1'b1, 0);
        tick(BIT_P);
        check_frames("b2b");
        check("b2b_hold", rx_data, 8'hFF);

        // 20-clock glitch on idle line
        done_before = n_done;
        rx_line = 1'b0;
        tick(20);
        rx_line = 1'b1;
        tick(3 * BIT_P);
        check("glitch_no_done", n_done, done_before);
        check("glitch_no_error", n_errp, exp_err);
        check("glitch_busy_run", (last_busy_run >= HALF_P - 2) && (last_busy_run <= HALF_P + 4), 1'b1);
        check("glitch_idle", rx_busy, 1'b0);

        // Framing error followed by a break, then a good 0x3C
        send_frame(8'h3C, BIT_P, 1'b0, 0);
        rx_line = 1'b0;
        tick(3 * BIT_P);
        check("break_idle", rx_busy, 1'b0);
        check("ferr_data_kept", rx_data, last_good);
        check_frames("ferr");
        rx_line = 1'b1;
        tick(2 * BIT_P);
        check_frames("break_quiet");
        send_frame(8'h3C, BIT_P, 1'b1, 0);
        tick(BIT_P);
        check_frames("after_ferr");

        // Reset pulse mid-data of 0x5A, then a fresh 0x5A
        send_frame(8'h5A, BIT_P, 1'b1, 250);
        check("midrst_data", rx_data, 8'h00);
        check("midrst_done", rx_done, 1'b0);
        check("midrst_error", rx_error, 1'b0);
        check("midrst_busy", rx_busy, 1'b0);
        last_good = 8'h00;
        tick(3 * BIT_P);
        check_frames("midrst_quiet");
        send_frame(8'h5A, BIT_P, 1'b1, 0);
        tick(BIT_P);
        check_frames("after_rst");

        // Sender rate mismatch
        send_frame(8'h96, 103, 1'b1, 0);
        tick(BIT_P);
        send_frame(8'h96, 107, 1'b1, 0);
        tick(BIT_P);
        check_frames("rate_mismatch");

        // Random bytes, random bit periods within +-2%, random gaps
        for (int n = 0; n < 8; n++) begin
            rb  = 8'($urandom_range(0, 255));
            rp  = $urandom_range(103, 107);
            gap = $urandom_range(0, 150);
            send_frame(rb, rp, 1'b1, 0);
            if (gap != 0) tick(gap);
        end
        tick(BIT_P);
        check_frames("random");
        check("final_data", rx_data, last_good);
        check("strobes_exclusive", both_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
